// File: rtl/life_controller.sv
// Control unit for the Game-of-Life datapath: debounces five raw buttons and
// sequences IDLE / PROGRAM / RUN / PAUSE, issuing registered command pulses.
module life_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GEN_PERIOD      = 8
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_clear,
  input  logic        btn0_in,
  input  logic        btn1_in,
  input  logic [63:0] grid,
  output logic [1:0]  state,
  output logic        prog_btn0,
  output logic        prog_btn1,
  output logic        gen_tick,
  output logic        stop,
  output logic [6:0]  cell_count,
  output logic [15:0] gen_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PROGRAM = 2'b01,
    RUN     = 2'b10,
    PAUSE   = 2'b11
  } mode_t;

  localparam int          NUM_BTN = 5;
  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] T_LAST  = 16'(GEN_PERIOD - 1);
  localparam logic [15:0] T_PRE   = 16'(GEN_PERIOD - 2);

  mode_t               mode;
  logic [15:0]         timer;
  logic [NUM_BTN-1:0]  raw, sync1, sync2, locked, press;
  logic [7:0]          db_cnt [NUM_BTN];
  logic                p_clear, p_pause, p_start, p_b0, p_b1;

  assign raw   = {btn1_in, btn0_in, btn_clear, btn_pause, btn_start};
  assign state = mode;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Synchronizers and debouncers. A press fires once after DEBOUNCE_CYCLES
  // consecutive high samples, then locks until a low sample is seen.
  always_ff @(posedge clka) begin
    // NOTE: the debounce counters are registers and are cleared by reset, so a
    // button held across reset release must re-qualify with fresh samples.
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      locked <= '0;
      press  <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        press[i] <= 1'b0;
        if (!sync2[i]) begin
          db_cnt[i] <= '0;
          locked[i] <= 1'b0;
        end else if (!locked[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            press[i]  <= 1'b1;
            locked[i] <= 1'b1;
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  // Same-cycle priority: clear masks pause, pause masks start.
  assign p_clear = press[2];
  assign p_pause = press[1] & ~press[2];
  assign p_start = press[0] & ~press[1] & ~press[2];
  assign p_b0    = press[3];
  assign p_b1    = press[4];

  always_ff @(posedge clka) begin
    if (rst) begin
      mode       <= IDLE;
      stop       <= 1'b1;
      gen_tick   <= 1'b0;
      prog_btn0  <= 1'b0;
      prog_btn1  <= 1'b0;
      cell_count <= '0;
      gen_count  <= '0;
      timer      <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle; branches below only raise
      // them, which guarantees single-cycle pulses without extra state.
      gen_tick  <= 1'b0;
      prog_btn0 <= 1'b0;
      prog_btn1 <= 1'b0;
      stop      <= 1'b0;
      if (p_clear) begin
        mode       <= IDLE;
        stop       <= ~stop;  // never back-to-back with an extinction stop
        cell_count <= '0;
        gen_count  <= '0;
        timer      <= '0;
      end else begin
        unique case (mode)
          IDLE: begin
            if (p_start) begin
              mode       <= PROGRAM;
              cell_count <= '0;
            end
          end
          PROGRAM: begin
            if (cell_count == 7'd64 || p_start) begin
              mode  <= RUN;
              timer <= '0;
            end else if (p_b0 ^ p_b1) begin
              prog_btn0  <= p_b0;
              prog_btn1  <= p_b1;
              cell_count <= cell_count + 7'd1;
            end
          end
          RUN: begin
            if (gen_tick && grid == '0) begin
              mode  <= IDLE;
              stop  <= 1'b1;
              timer <= '0;
            end else if (p_pause) begin
              mode <= PAUSE;
            end else begin
              timer <= (timer == T_LAST) ? '0 : timer + 16'd1;
              if (timer == T_PRE) begin
                gen_tick  <= 1'b1;
                gen_count <= sat_inc(gen_count);
              end
            end
          end
          PAUSE: begin
            if (p_pause) begin
              mode <= RUN;
            end else if (p_start) begin
              gen_tick  <= 1'b1;
              gen_count <= sat_inc(gen_count);
            end
          end
        endcase
      end
    end
  end

endmodule
